// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake and held result.
// Optional iterative shift-add multiplier is enabled with ALU_MUL_EN.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
`endif
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_valid;
  logic               r_ovf;
  logic               r_ill;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHAMT_W-1:0] w_sh;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_ill;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_sh   = b[SHAMT_W-1:0];

  // Single-cycle result and flags for every op except the multiplier.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    unique case (op)
      3'b000: begin
        w_res = w_sum;
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        w_res = w_diff;
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: w_res = a & b;
      3'b011: w_res = a | b;
      3'b100: w_res = a << w_sh;
      3'b101: w_res = a >> w_sh;
      3'b110: w_res = {{(WIDTH-1){1'b0}},
                       ($signed(a) < $signed(b))};
      3'b111: begin
        w_res = '0;
`ifdef ALU_MUL_EN
        w_ill = 1'b0;
`else
        w_ill = 1'b1;
`endif
      end
      default: w_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last    = (r_cnt == SHAMT_W'(WIDTH-1));

  // Shift-add datapath: load on accept, one partial product per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE && in_valid && op == 3'b111) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHAMT_W'(1);
    end
  end
`endif

  // Control FSM; result and flags change only on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MUL_EN
            if (op == 3'b111) r_state <= S_MUL;
            else
`endif
            begin
              r_result <= w_res;
              r_ovf    <= w_ovf;
              r_ill    <= w_ill;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          if (w_last) begin
            r_result <= w_acc_nxt[WIDTH-1:0];
            r_ovf    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            r_ill    <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign ovf       = r_ovf;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=32).
// Covers ALU_MUL_EN builds and the default build.
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    logic         i;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         illegal;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t   e;
    longint sx;
    longint sy;
    longint s;
    logic [2*W-1:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e  = '0;
    case (o)
      3'd0: begin
        e.r = x + y;
        s   = sx + sy;
        e.o = (s != longint'($signed(e.r)));
      end
      3'd1: begin
        e.r = x - y;
        s   = sx - sy;
        e.o = (s != longint'($signed(e.r)));
      end
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x << y[4:0];
      3'd5: e.r = x >> y[4:0];
      3'd6: e.r = (sx < sy) ? 1 : 0;
      default: begin
`ifdef ALU_MUL_EN
        p   = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.r = p[W-1:0];
        e.o = |p[2*W-1:W];
`else
        p   = '0;
        e.r = p[W-1:0];
        e.i = 1'b1;
`endif
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Drive one bundle from a negedge, wait for the result, score it.
  task automatic issue(input logic [2:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic rdy,
                       input logic poke);
    exp_t g;
    int   lat;
    int   elat;
    out_ready = rdy;
    q.push_back(model(o, x, y));
    chk("accept_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (poke && lat == 3) begin
        in_valid = 1'b1;
        op = 3'd0;
        a  = 1;
        b  = 1;
        chk("busy_ready", W'(in_ready), W'(0));
      end
      if (poke && lat == 6) in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    elat = (o == 3'd7) ? MUL_LAT : 1;
    chk("latency", W'(lat), W'(elat));
    chk("out_valid", W'(out_valid), W'(1));
    g = q.pop_front();
    chk("result", result, g.r);
    chk("zero", W'(zero), W'(g.z));
    chk("ovf", W'(ovf), W'(g.o));
    chk("illegal", W'(illegal), W'(g.i));
  endtask

  // Hold the result for some cycles, then hand it off.
  task automatic drain(input int hold);
    logic [W-1:0] held;
    held = result;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_result", result, held);
      chk("hold_ready", W'(in_ready), W'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drop_valid", W'(out_valid), W'(0));
    chk("back_ready", W'(in_ready), W'(1));
    chk("kept_result", result, held);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready", W'(in_ready), W'(1));
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_result", result, W'(0));
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_ovf", W'(ovf), W'(0));
    chk("rst_illegal", W'(illegal), W'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0);
    drain(0);
    issue(3'd1, 32'd5, 32'd5, 1'b0, 1'b0);
    drain(4);
    issue(3'd4, 32'h1, 32'h25, 1'b1, 1'b0);
    drain(0);
    issue(3'd5, 32'h8000_0000, 32'd31, 1'b1, 1'b0);
    drain(0);
    issue(3'd6, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    drain(0);
    issue(3'd6, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain(0);
    issue(3'd1, 32'h8000_0000, 32'h1, 1'b1, 1'b0);
    drain(0);
    issue(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
    drain(0);

`ifdef ALU_MUL_EN
    issue(3'd7, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    drain(0);
    issue(3'd7, 32'd3, 32'd7, 1'b1, 1'b1);
    drain(0);
    repeat (2) @(negedge clk);
    chk("no_stray_valid", W'(out_valid), W'(0));
    chk("mid_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    op = 3'd7;
    a  = 32'd9;
    b  = 32'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul_busy", W'(in_ready), W'(0));
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_valid", W'(out_valid), W'(0));
    chk("abort_result", result, W'(0));
    chk("abort_ready", W'(in_ready), W'(1));
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("abort_quiet", W'(out_valid), W'(0));
`else
    issue(3'd7, 32'd3, 32'd7, 1'b1, 1'b0);
    drain(0);
    issue(3'd3, 32'd1, 32'd2, 1'b1, 1'b0);
    drain(0);
    issue(3'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_valid", W'(out_valid), W'(0));
    chk("abort_result", result, W'(0));
    chk("abort_zero", W'(zero), W'(1));
    chk("abort_ready", W'(in_ready), W'(1));
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
`endif

    issue(3'd2, 32'hF0, 32'h3C, 1'b1, 1'b0);
    drain(0);
    issue(3'd3, 32'd1, 32'd2, 1'b1, 1'b0);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
